matrix_elem_divider: RTL and testbench

Element-wise fixed-point divider for H×W matrices, computing Y[i][j] = A[i][j] / B[i][j] in signed Qx.FRACT_WIDTH format. It is the inverse companion of the element-wise multiplier, used where normalised feature maps must be de-scaled. One element is processed at a time on a bit-serial restoring divider, trading latency for area. Operands and results move over valid/ready handshakes.

---
 rtl/fxp_pkg.sv | 31 +++
 rtl/fxp_serial_div.sv | 73 +++++++
 rtl/matrix_elem_divider.sv | 155 +++++++++++++++
 tb/tb_matrix_elem_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point element-wise divider: FSM encoding,
// divider width and saturation bound helpers.
package fxp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FRACT_WIDTH = 8;

    function automatic int div_width(input int data_width, input int fract_width);
        return data_width + fract_width;
    endfunction

    localparam int DEF_N = DEF_DATA_WIDTH + DEF_FRACT_WIDTH;

    // Bounds are returned in 64 bits; callers keep the low DATA_WIDTH bits.
    function automatic logic [63:0] sat_max(input int data_width);
        return (64'd1 << (data_width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int data_width);
        return 64'd1 << (data_width - 1);
    endfunction

endpackage

// File: rtl/fxp_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The start cycle performs the first step, so done pulses N cycles after start.
module fxp_serial_div #(
    parameter int N  = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [DW:0]   divisor,
    output logic [N-1:0]  quotient,
    output logic          done
);

    localparam int CW = $clog2(N + 1);

    logic [DW:0]   r_rem;
    logic [DW:0]   r_div;
    logic [N-1:0]  r_q;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic [DW:0]   w_rem_in;
    logic [N-1:0]  w_q_in;
    logic [DW:0]   w_dvs;
    logic [DW+1:0] w_trial;
    logic [DW+1:0] w_diff;
    logic          w_ge;
    logic [DW:0]   w_rem_nx;

    // r_q starts as the dividend and shifts quotient bits in from the right.
    always_comb begin
        w_rem_in = start ? '0 : r_rem;
        w_q_in   = start ? dividend : r_q;
        w_dvs    = start ? divisor : r_div;
        w_trial  = {w_rem_in, w_q_in[N-1]};
        w_diff   = w_trial - {1'b0, w_dvs};
        w_ge     = (w_trial >= {1'b0, w_dvs});
        w_rem_nx = w_ge ? (DW+1)'(w_diff) : (DW+1)'(w_trial);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_nx;
            r_q    <= {w_q_in[N-2:0], w_ge};
            r_div  <= divisor;
            r_cnt  <= CW'(N - 1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_nx;
            r_q    <= {w_q_in[N-2:0], w_ge};
            r_cnt  <= r_cnt - CW'(1);
            r_busy <= (r_cnt != CW'(1));
            r_done <= (r_cnt == CW'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign quotient = r_q;
    assign done     = r_done;

endmodule

// File: rtl/matrix_elem_divider.sv
// Element-wise signed fixed-point matrix divider Y = A ./ B, one element at a
// time through a shared serial divider, with valid/ready on both sides.
module matrix_elem_divider
    import fxp_pkg::*;
#(
    parameter int H           = 8,
    parameter int W           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [H*W*DATA_WIDTH-1:0] a,
    input  logic [H*W*DATA_WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [H*W*DATA_WIDTH-1:0] y,
    output logic                      div_by_zero,
    output logic [2:0]                o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready only in IDLE, out_valid only in DONE (held until taken).

    localparam int DW = DATA_WIDTH;
    localparam int FW = FRACT_WIDTH;
    localparam int NE = H * W;
    localparam int PW = NE * DW;
    localparam int N  = div_width(DW, FW);
    localparam int KW = (NE > 1) ? $clog2(NE) : 1;

    localparam logic [63:0]   SAT_MAX_64 = sat_max(DW);
    localparam logic [63:0]   SAT_MIN_64 = sat_min(DW);
    localparam logic [DW-1:0] SAT_MAX    = SAT_MAX_64[DW-1:0];
    localparam logic [DW-1:0] SAT_MIN    = SAT_MIN_64[DW-1:0];
    localparam logic [N-1:0]  POS_LIM    = N'(SAT_MAX_64);
    localparam logic [N-1:0]  NEG_LIM    = N'(SAT_MIN_64);

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_a;
    logic [PW-1:0] r_b;
    logic [PW-1:0] r_y;
    logic [KW-1:0] r_k;
    logic          r_sign;
    logic          r_dbz;

    logic [DW-1:0] w_a_el;
    logic [DW-1:0] w_b_el;
    logic [DW-1:0] w_abs_a;
    logic [DW:0]   w_b_ext;
    logic [DW:0]   w_abs_b;
    logic [N-1:0]  w_dividend;
    logic          w_sign;
    logic          w_start;
    logic [N-1:0]  w_q;
    logic          w_div_done;
    logic [DW-1:0] w_sat;
    logic          w_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_DIV;
            ST_DIV:   if (w_div_done) w_next = ST_STORE;
            ST_STORE: w_next = w_last ? ST_DONE : ST_LOAD;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        out_valid = (r_state == ST_DONE);
        w_start   = (r_state == ST_LOAD);
    end

    // The low DW bits of the negation are exact even for the most negative a.
    always_comb begin
        w_a_el     = r_a[int'(r_k) * DW +: DW];
        w_b_el     = r_b[int'(r_k) * DW +: DW];
        w_sign     = w_a_el[DW-1] ^ w_b_el[DW-1];
        w_abs_a    = w_a_el[DW-1] ? (~w_a_el + DW'(1)) : w_a_el;
        w_b_ext    = {w_b_el[DW-1], w_b_el};
        w_abs_b    = w_b_el[DW-1] ? (~w_b_ext + (DW+1)'(1)) : w_b_ext;
        w_dividend = {w_abs_a, {FW{1'b0}}};
        w_last     = (r_k == KW'(NE - 1));
    end

    fxp_serial_div #(
        .N  (N),
        .DW (DW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_dividend),
        .divisor  (w_abs_b),
        .quotient (w_q),
        .done     (w_div_done)
    );

    // Divide-by-zero yields an all-ones quotient, which saturates by sign.
    always_comb begin
        if (!r_sign) w_sat = (w_q > POS_LIM) ? SAT_MAX : w_q[DW-1:0];
        else         w_sat = (w_q > NEG_LIM) ? SAT_MIN : DW'(~w_q + N'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_y    <= '0;
            r_k    <= '0;
            r_sign <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_k   <= '0;
                        r_dbz <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_sign <= w_sign;
                    if (w_b_el == '0) r_dbz <= 1'b1;
                end
                ST_STORE: begin
                    r_y[int'(r_k) * DW +: DW] <= w_sat;
                    r_k <= w_last ? '0 : r_k + KW'(1);
                end
                ST_DONE: begin
                    if (out_ready) r_dbz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign y           = r_y;
    assign div_by_zero = r_dbz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matrix_elem_divider.sv
// Directed bench for matrix_elem_divider on a 2x2 Q7.8 configuration with
// hand-computed quotients, latency, backpressure and mid-operation reset.
module tb_matrix_elem_divider;

    localparam int H       = 2;
    localparam int W       = 2;
    localparam int DW      = 16;
    localparam int FW      = 8;
    localparam int NE      = H * W;
    localparam int PW      = NE * DW;
    localparam int EXP_LAT = NE * (DW + FW + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] a = '0;
    logic [PW-1:0] b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] y;
    logic          div_by_zero;
    logic [2:0]    dbg_state;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];

    matrix_elem_divider #(
        .H           (H),
        .W           (W),
        .DATA_WIDTH  (DW),
        .FRACT_WIDTH (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .div_by_zero (div_by_zero),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack4(input logic [DW-1:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic push_exp(input logic [DW-1:0] e0, e1, e2, e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    task automatic check_y(input string tag);
        logic [DW-1:0] e;
        for (int k = 0; k < NE; k++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s y[%0d]", tag, k), 32'(y[k*DW +: DW]), 32'(e));
        end
    endtask

    task automatic start_txn(input logic [PW-1:0] av, input logic [PW-1:0] bv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_eq("in_ready wait", 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(EXP_LAT));
    endtask

    task automatic accept_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq({tag, " in_ready after accept"}, 32'(in_ready), 32'd1);
        check_eq({tag, " out_valid after accept"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [PW-1:0] basic_a, basic_b, dz_a, dz_b, sat_a, sat_b, tr_a, tr_b;
        logic [PW-1:0] held_y;
        logic          held_dbz;
        int            viol;

        basic_a = pack4(16'h0300, 16'h0100, 16'hFE00, 16'h0080);
        basic_b = pack4(16'h0200, 16'h0300, 16'h0100, 16'hFF00);
        dz_a    = pack4(16'h0100, 16'hFF00, 16'h0000, 16'h0200);
        dz_b    = pack4(16'h0000, 16'h0000, 16'h0000, 16'h0100);
        sat_a   = pack4(16'h7F00, 16'h8000, 16'h8000, 16'h0100);
        sat_b   = pack4(16'h0001, 16'h0001, 16'hFF00, 16'h0100);
        tr_a    = pack4(16'hFF00, 16'h0100, 16'hFFFF, 16'h0001);
        tr_b    = pack4(16'h0300, 16'hFD00, 16'h0200, 16'h0200);

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("in_ready during rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset y nonzero", 32'(y != '0), 32'd0);
        check_eq("reset div_by_zero", 32'(div_by_zero), 32'd0);
        check_eq("reset state", 32'(dbg_state), 32'd0);

        // Basic
        start_txn(basic_a, basic_b);
        wait_done("basic");
        push_exp(16'h0180, 16'h0055, 16'hFE00, 16'hFF80);
        check_y("basic");
        check_eq("basic div_by_zero", 32'(div_by_zero), 32'd0);
        accept_out("basic");

        // Divide by zero
        start_txn(dz_a, dz_b);
        wait_done("dz");
        push_exp(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0200);
        check_y("dz");
        check_eq("dz div_by_zero", 32'(div_by_zero), 32'd1);
        accept_out("dz");
        check_eq("dz flag cleared", 32'(div_by_zero), 32'd0);

        // Saturation
        start_txn(sat_a, sat_b);
        wait_done("sat");
        push_exp(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0100);
        check_y("sat");
        check_eq("sat div_by_zero", 32'(div_by_zero), 32'd0);
        accept_out("sat");

        // Truncation, then backpressure while holding DONE
        start_txn(tr_a, tr_b);
        wait_done("trunc");
        push_exp(16'hFFAB, 16'hFFAB, 16'h0000, 16'h0000);
        check_y("trunc");
        held_y   = y;
        held_dbz = div_by_zero;
        viol     = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (y !== held_y || div_by_zero !== held_dbz || out_valid !== 1'b1 || in_ready !== 1'b0)
                viol++;
        end
        check_eq("bp hold violations", 32'(viol), 32'd0);

        // Release and present the next transaction back to back
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = basic_a;
        b = basic_b;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq("bp in_ready after release", 32'(in_ready), 32'd1);
        check_eq("bp out_valid after release", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_eq("b2b accepted", 32'(in_ready), 32'd0);
        wait_done("b2b");
        push_exp(16'h0180, 16'h0055, 16'hFE00, 16'hFF80);
        check_y("b2b");
        accept_out("b2b");

        // Reset while element 2 is dividing
        start_txn(dz_a, dz_b);
        repeat (60) @(posedge clk);
        #1;
        check_eq("midrst in DIV", 32'(dbg_state), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("midrst out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst y nonzero", 32'(y != '0), 32'd0);
        check_eq("midrst in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst div_by_zero", 32'(div_by_zero), 32'd0);

        start_txn(basic_a, basic_b);
        wait_done("post-rst");
        push_exp(16'h0180, 16'h0055, 16'hFE00, 16'hFF80);
        check_y("post-rst");
        check_eq("post-rst div_by_zero", 32'(div_by_zero), 32'd0);
        accept_out("post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
